bnn_cmd_controller: RTL
=======================

Name: bnn_cmd_controller

Overview:
- Parametrised successor to the SPI command FSM between the SPI slave, the image buffer and the BNN core.
- Decodes command bytes and streams exactly IMG_BYTES data bytes into the buffer with a write handshake.
- Pulses the BNN to start, latches its result and returns status/result bytes over SPI.
- Adds an inactivity timeout, overflow/unknown-command error codes and binary-safe image reception (no in-band command decode during image data).

Parameters:
- DATA_W, 8: SPI byte width.
- IMG_BYTES, 113: image payload length in bytes.
- ADDR_W, 7: buffer address width; must satisfy 2**ADDR_W >= IMG_BYTES.
- RESULT_W, 4: BNN class-index width; must be <= DATA_W-4.
- TIMEOUT_CYCLES, 100000: maximum clk cycles between bytes in WAIT_IMG/IMG_RX.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- spi_rx_data  in  DATA_W  received byte, stable while spi_rx_valid is high
- spi_rx_valid  in  1  level valid from the SPI slave; a rising edge marks a new byte
- rx_enable  out  1  SPI receive permitted
- spi_tx_data  out  DATA_W  reply byte {status_code, result zero-extended}
- spi_tx_load  out  1  one-cycle pulse: SPI slave reloads its tx shift register
- status_code  out  4  0 IDLE, 1 RX_RDY, 2 RX_IMG, 4 BNN_BUSY, 8 RESULT_RDY, 14 ERROR
- err_code  out  2  0 none, 1 timeout, 2 overflow, 3 unknown command
- buf_wr_req  out  1  one-cycle write strobe
- buf_wr_ready  in  1  buffer can accept a write
- buf_wr_addr  out  ADDR_W  write address
- buf_wr_data  out  DATA_W  write data
- buf_clear  out  1  clear buffer, held high while in CLEAR
- buf_empty  in  1  buffer empty
- bnn_start  out  1  one-cycle start pulse
- bnn_done  in  1  result valid (pulse or level)
- bnn_result  in  RESULT_W  class index, valid while bnn_done is high

Behaviour:
- Reset values: all outputs 0. State IDLE; status 0; err 0; address counter 0; result register 0; valid_q 0; timeout counter 0.
- Byte detection: new_byte = spi_rx_valid & ~valid_q, where valid_q is valid registered. Each byte is acted on exactly once.
- All outputs are registered. An action triggered by new_byte at cycle N is visible at N+1. buf_wr_ready is sampled at cycle N.
- Commands: CMD_IMG_SEND=0xFE, CMD_CLEAR=0xFD, CMD_READ_RESULT=0xFC, CMD_STATUS=0xFB.
- IDLE (rx_enable=1):
  - FE -> WAIT_IMG, status 1.
  - FD -> CLEAR.
  - FB -> spi_tx_load pulse.
  - Any other byte -> ERROR, err 3.
- WAIT_IMG (rx_enable=1):
  - First byte is image data: write at address 0, counter becomes 1, -> IMG_RX, status 2.
- IMG_RX (rx_enable=1): every byte is data, including 0xFD.
  - Write at address = counter, then counter++.
  - When the IMG_BYTES-th write issues (counter == IMG_BYTES-1 at detection) -> BNN_RUN, status 4, bnn_start pulses in the same cycle as that final buf_wr_req.
- Overflow: new_byte in WAIT_IMG/IMG_RX with buf_wr_ready=0 -> no write, ERROR, err 2.
- Timeout: counter clears on every new_byte and on entry to WAIT_IMG.
  - Reaching TIMEOUT_CYCLES-1 in WAIT_IMG/IMG_RX -> ERROR, err 1.
  - A new_byte in that same cycle wins (byte is processed, no timeout).
- BNN_RUN (rx_enable=1):
  - bnn_done -> latch bnn_result, -> RESULT, status 8, spi_tx_load pulse.
  - FD -> CLEAR; it wins if it coincides with bnn_done.
  - Other bytes are ignored.
- RESULT:
  - FC or FB -> spi_tx_load pulse.
  - FD -> CLEAR.
  - Other bytes are ignored.
- ERROR (rx_enable=1):
  - status 14; only FD is honoured -> CLEAR.
  - FB -> spi_tx_load pulse.
- CLEAR (rx_enable=0):
  - buf_clear=1; address counter, result register and err cleared on entry.
  - buf_empty=1 -> IDLE, status 0. With buf_empty already high, CLEAR lasts exactly 1 cycle.
- spi_tx_data always reflects the current status_code and result register.
- Reset mid-operation: immediate return to reset values. Pending writes and bnn_start are cancelled.
- Illegal state encoding -> IDLE, status 14.

Decomposition:
- Shared package bnn_ctrl_pkg holds:
  - the state enum;
  - status codes, command bytes and err codes as localparams;
  - the tx packing function.
- One sub-module, byte_edge_detect: valid_q register plus new_byte output, reused by the SPI result path.

Test Plan:
- Reset, FE, then 113 bytes 0x00..0x70 with ready=1 -> writes to addresses 0..112 with matching data, status 1->2->4, a single bnn_start on the last write.
- Image containing 0xFD at byte 50 -> written as data at address 50; no CLEAR.
- bnn_done with result=7 -> status 8, spi_tx_data=0x87, spi_tx_load pulse; FC -> another pulse.
- FE, 10 bytes, then idle for TIMEOUT_CYCLES -> status 14, err 1; FD with buf_empty=1 -> IDLE, err 0, next image starts at address 0.
- Byte while buf_wr_ready=0 -> no buf_wr_req, err 2. Byte 0x42 in IDLE -> err 3.
- FD in the same cycle as bnn_done -> CLEAR, result register stays 0. rst_n low mid-image -> all outputs 0 within the reset.

Source files
------------

// File: rtl/bnn_ctrl_pkg.sv
// Shared definitions for the BNN command controller.
// Holds the FSM state encoding, SPI command bytes, status and error codes,
// and the helper that packs the reply byte {status_code, result}.
package bnn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_IMG = 3'd1,
    S_IMG_RX   = 3'd2,
    S_BNN_RUN  = 3'd3,
    S_RESULT   = 3'd4,
    S_ERROR    = 3'd5,
    S_CLEAR    = 3'd6
  } state_e;

  localparam logic [3:0] STAT_IDLE       = 4'd0;
  localparam logic [3:0] STAT_RX_RDY     = 4'd1;
  localparam logic [3:0] STAT_RX_IMG     = 4'd2;
  localparam logic [3:0] STAT_BNN_BUSY   = 4'd4;
  localparam logic [3:0] STAT_RESULT_RDY = 4'd8;
  localparam logic [3:0] STAT_ERROR      = 4'd14;

  localparam logic [7:0] CMD_IMG_SEND    = 8'hFE;
  localparam logic [7:0] CMD_CLEAR       = 8'hFD;
  localparam logic [7:0] CMD_READ_RESULT = 8'hFC;
  localparam logic [7:0] CMD_STATUS      = 8'hFB;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_UNKNOWN  = 2'd3;

  // Status sits in the top nibble of a data_w-bit reply; result is
  // zero-extended below it. Caller truncates to its own byte width.
  function automatic logic [31:0] pack_tx(input logic [3:0]  status,
                                          input logic [31:0] result,
                                          input int unsigned data_w);
    return (32'(status) << (data_w - 32'd4)) | result;
  endfunction

endpackage

// File: rtl/bnn_cmd_controller_if.sv
// Bundle of all SPI, image-buffer and BNN-core signals seen by the controller.
//   master : controller side (drives rx_enable, spi_tx_*, status/err, buf_wr_*,
//            buf_clear, bnn_start)
//   slave  : environment side (drives spi_rx_*, buf_wr_ready, buf_empty,
//            bnn_done, bnn_result)
interface bnn_cmd_controller_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned RESULT_W = 4
);
  logic [DATA_W-1:0]   spi_rx_data;
  logic                spi_rx_valid;
  logic                rx_enable;
  logic [DATA_W-1:0]   spi_tx_data;
  logic                spi_tx_load;
  logic [3:0]          status_code;
  logic [1:0]          err_code;
  logic                buf_wr_req;
  logic                buf_wr_ready;
  logic [ADDR_W-1:0]   buf_wr_addr;
  logic [DATA_W-1:0]   buf_wr_data;
  logic                buf_clear;
  logic                buf_empty;
  logic                bnn_start;
  logic                bnn_done;
  logic [RESULT_W-1:0] bnn_result;

  modport master (
    input  spi_rx_data, spi_rx_valid, buf_wr_ready, buf_empty, bnn_done, bnn_result,
    output rx_enable, spi_tx_data, spi_tx_load, status_code, err_code,
           buf_wr_req, buf_wr_addr, buf_wr_data, buf_clear, bnn_start
  );

  modport slave (
    output spi_rx_data, spi_rx_valid, buf_wr_ready, buf_empty, bnn_done, bnn_result,
    input  rx_enable, spi_tx_data, spi_tx_load, status_code, err_code,
           buf_wr_req, buf_wr_addr, buf_wr_data, buf_clear, bnn_start
  );
endinterface

// File: rtl/bnn_cmd_controller_byte_edge_detect.sv
// Turns the SPI slave's level valid into a single-cycle new_byte strobe.
//   clk, rst_n : clock, async active-low reset
//   valid      : level valid from the SPI slave
//   new_byte   : high for the one cycle where valid rises
module byte_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  output logic new_byte
);
  logic valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid;
  end

  assign new_byte = valid & ~valid_q;
endmodule

// File: rtl/bnn_cmd_controller.sv
// SPI command controller between SPI slave, image buffer and BNN core.
// Decodes command bytes, streams IMG_BYTES image bytes into the buffer,
// starts the BNN, latches its result and reports status over SPI.
//   clk, rst_n : clock, async active-low reset
//   bus        : bnn_cmd_controller_if.master (all SPI/buffer/BNN signals)
// Every output is registered: a byte detected at cycle N acts at N+1.
module bnn_cmd_controller
  import bnn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned IMG_BYTES      = 113,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned RESULT_W       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 rst_n,
  bnn_cmd_controller_if.master bus
);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] C_IMG     = DATA_W'(CMD_IMG_SEND);
  localparam logic [DATA_W-1:0] C_CLR     = DATA_W'(CMD_CLEAR);
  localparam logic [DATA_W-1:0] C_RD      = DATA_W'(CMD_READ_RESULT);
  localparam logic [DATA_W-1:0] C_STAT    = DATA_W'(CMD_STATUS);

  logic new_byte;

  byte_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (bus.spi_rx_valid),
    .new_byte (new_byte)
  );

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [1:0]          err_q, err_d;
  logic [3:0]          status_q, status_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                tx_load_q, tx_load_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                start_q, start_d;
  logic                rx_en_q, clear_q;
  logic [DATA_W-1:0]   tx_data_q;

  logic [DATA_W-1:0] rx_byte;
  assign rx_byte = bus.spi_rx_data;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    result_d  = result_q;
    err_d     = err_q;
    status_d  = status_q;
    tcnt_d    = new_byte ? '0 : tcnt_q;
    tx_load_d = 1'b0;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;

    case (state_q)
      S_IDLE: if (new_byte) begin
        if (rx_byte == C_IMG) begin
          state_d  = S_WAIT_IMG;
          status_d = STAT_RX_RDY;
          addr_d   = '0;
          tcnt_d   = '0;
        end else if (rx_byte == C_CLR) begin
          state_d  = S_CLEAR;
        end else if (rx_byte == C_STAT) begin
          tx_load_d = 1'b1;
        end else begin
          state_d  = S_ERROR;
          status_d = STAT_ERROR;
          err_d    = ERR_UNKNOWN;
        end
      end

      // Image bytes are pure data: no command decode here, 0xFD included.
      S_WAIT_IMG, S_IMG_RX: begin
        if (new_byte) begin
          if (!bus.buf_wr_ready) begin
            state_d  = S_ERROR;
            status_d = STAT_ERROR;
            err_d    = ERR_OVERFLOW;
          end else begin
            wr_req_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_byte;
            addr_d    = addr_q + ADDR_W'(1);
            if (addr_q == LAST_ADDR) begin
              state_d  = S_BNN_RUN;
              status_d = STAT_BNN_BUSY;
              start_d  = 1'b1;
            end else begin
              state_d  = S_IMG_RX;
              status_d = STAT_RX_IMG;
            end
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d  = S_ERROR;
          status_d = STAT_ERROR;
          err_d    = ERR_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      // A clear request outranks a result arriving in the same cycle.
      S_BNN_RUN: begin
        if (new_byte && rx_byte == C_CLR) begin
          state_d = S_CLEAR;
        end else if (bus.bnn_done) begin
          result_d  = bus.bnn_result;
          state_d   = S_RESULT;
          status_d  = STAT_RESULT_RDY;
          tx_load_d = 1'b1;
        end
      end

      S_RESULT: if (new_byte) begin
        if (rx_byte == C_RD || rx_byte == C_STAT) tx_load_d = 1'b1;
        else if (rx_byte == C_CLR)                state_d   = S_CLEAR;
      end

      S_ERROR: if (new_byte) begin
        if (rx_byte == C_CLR)       state_d   = S_CLEAR;
        else if (rx_byte == C_STAT) tx_load_d = 1'b1;
      end

      S_CLEAR: if (bus.buf_empty) begin
        state_d  = S_IDLE;
        status_d = STAT_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        status_d = STAT_ERROR;
      end
    endcase

    // Entry into CLEAR wipes the image pointer, result and error.
    if (state_d == S_CLEAR && state_q != S_CLEAR) begin
      addr_d   = '0;
      result_d = '0;
      err_d    = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      result_q  <= '0;
      err_q     <= ERR_NONE;
      status_q  <= STAT_IDLE;
      tcnt_q    <= '0;
      tx_load_q <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      clear_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      result_q  <= result_d;
      err_q     <= err_d;
      status_q  <= status_d;
      tcnt_q    <= tcnt_d;
      tx_load_q <= tx_load_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      rx_en_q   <= (state_d != S_CLEAR);
      clear_q   <= (state_d == S_CLEAR);
      tx_data_q <= DATA_W'(pack_tx(status_d, 32'(result_d), DATA_W));
    end
  end

  assign bus.rx_enable   = rx_en_q;
  assign bus.spi_tx_data = tx_data_q;
  assign bus.spi_tx_load = tx_load_q;
  assign bus.status_code = status_q;
  assign bus.err_code    = err_q;
  assign bus.buf_wr_req  = wr_req_q;
  assign bus.buf_wr_addr = wr_addr_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.buf_clear   = clear_q;
  assign bus.bnn_start   = start_q;
endmodule
